// File: rtl/bomb_scheduler_if.sv
// Bomb scheduler bus: drop request inputs and per-slot bomb state outputs.
// The scheduler is the slave; the player/renderer side is the master.
interface bomb_scheduler_if #(
  parameter int unsigned NSLOTS  = 2,
  parameter int unsigned COORD_W = 10
);
  logic                       tick;
  logic                       game_en;
  logic                       drop_btn;
  logic [COORD_W-1:0]         pos_x;
  logic [COORD_W-1:0]         pos_y;
  logic                       drop_ack;
  logic                       drop_nack;
  logic [NSLOTS*COORD_W-1:0]  bomb_x;
  logic [NSLOTS*COORD_W-1:0]  bomb_y;
  logic [NSLOTS-1:0]          armed;
  logic [NSLOTS-1:0]          exploding;
  logic [NSLOTS-1:0]          visible;
  logic [NSLOTS-1:0]          explode_start;
  logic [2:0]                 active_cnt;

  modport master (
    output tick, game_en, drop_btn, pos_x, pos_y,
    input  drop_ack, drop_nack, bomb_x, bomb_y, armed, exploding, visible,
           explode_start, active_cnt
  );

  modport slave (
    input  tick, game_en, drop_btn, pos_x, pos_y,
    output drop_ack, drop_nack, bomb_x, bomb_y, armed, exploding, visible,
           explode_start, active_cnt
  );
endinterface

// File: rtl/bomb_scheduler.sv
// Multi-slot bomb scheduler: arbitrates drop requests into free slots and runs
// each slot's fuse/explosion countdown on the game tick.
module bomb_scheduler #(
  parameter int unsigned NSLOTS        = 2,
  parameter int unsigned FUSE_TICKS    = 96,
  parameter int unsigned EXPLODE_TICKS = 24,
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned BLINK_BIT     = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  bomb_scheduler_if.slave bus
);

  localparam int unsigned CNT_MAX = (FUSE_TICKS > EXPLODE_TICKS) ? FUSE_TICKS : EXPLODE_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned XY_W    = NSLOTS * COORD_W;
  localparam int unsigned SLOT_W  = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  // Bit 0 doubles as the armed flag, bit 1 as the exploding flag.
  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_EXPLODE = 2'b10;

  logic [1:0]        r_state [NSLOTS];
  logic [CNT_W-1:0]  r_cnt   [NSLOTS];
  logic [XY_W-1:0]   r_bomb_x, r_bomb_y;
  logic              r_btn_prev, r_pending, r_ack, r_nack;
  logic [NSLOTS-1:0] r_start, r_visible;
  logic [2:0]        r_active;

  logic [1:0]        w_state_nxt [NSLOTS];
  logic [CNT_W-1:0]  w_cnt_nxt   [NSLOTS];
  logic [XY_W-1:0]   w_bomb_x_nxt, w_bomb_y_nxt;
  logic              w_pending_nxt, w_ack_nxt, w_nack_nxt;
  logic [NSLOTS-1:0] w_start_nxt, w_visible_nxt;
  logic [2:0]        w_active_nxt;
  logic              w_free, w_dup, w_rise;
  logic [SLOT_W-1:0] w_free_idx;

  // Next-state: slot countdowns, allocation, pending request and pulses.
  always_comb begin
    for (int i = 0; i < NSLOTS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
    end
    w_bomb_x_nxt  = r_bomb_x;
    w_bomb_y_nxt  = r_bomb_y;
    w_pending_nxt = r_pending;
    w_ack_nxt     = 1'b0;
    w_nack_nxt    = 1'b0;
    w_start_nxt   = '0;
    w_visible_nxt = '0;
    w_active_nxt  = 3'd0;
    w_free        = 1'b0;
    w_free_idx    = '0;
    w_dup         = 1'b0;
    w_rise        = bus.drop_btn & ~r_btn_prev;

    // Free-slot search and duplicate check look only at the pre-tick state.
    for (int i = 0; i < NSLOTS; i++) begin
      if (r_state[i] != S_IDLE) w_active_nxt = w_active_nxt + 3'd1;
      if (!w_free && r_state[i] == S_IDLE) begin
        w_free     = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
      if (r_state[i] == S_ARMED &&
          r_bomb_x[i*COORD_W +: COORD_W] == bus.pos_x &&
          r_bomb_y[i*COORD_W +: COORD_W] == bus.pos_y) w_dup = 1'b1;
    end

    if (!bus.game_en) begin
      for (int i = 0; i < NSLOTS; i++) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
      end
      w_pending_nxt = 1'b0;
    end else begin
      if (bus.tick) begin
        for (int i = 0; i < NSLOTS; i++) begin
          case (r_state[i])
            S_ARMED: begin
              if (r_cnt[i] == CNT_W'(1)) begin
                w_state_nxt[i] = S_EXPLODE;
                w_cnt_nxt[i]   = CNT_W'(EXPLODE_TICKS);
                w_start_nxt[i] = 1'b1;
              end else begin
                w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
              end
            end
            S_EXPLODE: begin
              if (r_cnt[i] == CNT_W'(1)) begin
                w_state_nxt[i] = S_IDLE;
                w_cnt_nxt[i]   = '0;
              end else begin
                w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
        if (r_pending) begin
          w_pending_nxt = 1'b0;
          if (w_free && !w_dup) begin
            w_ack_nxt = 1'b1;
            for (int i = 0; i < NSLOTS; i++) begin
              if (SLOT_W'(i) == w_free_idx) begin
                w_state_nxt[i] = S_ARMED;
                w_cnt_nxt[i]   = CNT_W'(FUSE_TICKS);
                w_bomb_x_nxt[i*COORD_W +: COORD_W] = bus.pos_x;
                w_bomb_y_nxt[i*COORD_W +: COORD_W] = bus.pos_y;
              end
            end
          end else begin
            w_nack_nxt = 1'b1;
          end
        end
      end
      // An edge landing on the consuming tick is dropped: one drop per tick.
      if (!(bus.tick && r_pending) && w_rise) w_pending_nxt = 1'b1;
    end

    for (int i = 0; i < NSLOTS; i++)
      w_visible_nxt[i] = (w_state_nxt[i] == S_ARMED) && !w_cnt_nxt[i][BLINK_BIT];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSLOTS; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
      r_bomb_x   <= '0;
      r_bomb_y   <= '0;
      r_btn_prev <= 1'b0;
      r_pending  <= 1'b0;
      r_ack      <= 1'b0;
      r_nack     <= 1'b0;
      r_start    <= '0;
      r_visible  <= '0;
      r_active   <= 3'd0;
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_bomb_x   <= w_bomb_x_nxt;
      r_bomb_y   <= w_bomb_y_nxt;
      r_btn_prev <= bus.drop_btn;
      r_pending  <= w_pending_nxt;
      r_ack      <= w_ack_nxt;
      r_nack     <= w_nack_nxt;
      r_start    <= w_start_nxt;
      r_visible  <= w_visible_nxt;
      r_active   <= w_active_nxt;
    end
  end

  for (genvar g = 0; g < NSLOTS; g++) begin : g_slot_out
    assign bus.armed[g]     = r_state[g][0];
    assign bus.exploding[g] = r_state[g][1];
  end

  assign bus.drop_ack      = r_ack;
  assign bus.drop_nack     = r_nack;
  assign bus.bomb_x        = r_bomb_x;
  assign bus.bomb_y        = r_bomb_y;
  assign bus.visible       = r_visible;
  assign bus.explode_start = r_start;
  assign bus.active_cnt    = r_active;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: lifecycle, full/duplicate refusal,
// slot-freeing race, blink, game_en clear and async reset.
module tb_bomb_scheduler;

  localparam int unsigned NSLOTS  = 2;
  localparam int unsigned COORD_W = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bomb_scheduler_if #(.NSLOTS(NSLOTS), .COORD_W(COORD_W)) bus ();

  bomb_scheduler #(
    .NSLOTS(NSLOTS), .FUSE_TICKS(96), .EXPLODE_TICKS(24),
    .COORD_W(COORD_W), .BLINK_BIT(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic              got_ack, got_nack;
  logic [NSLOTS-1:0] got_start;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Tick for one cycle, capture the pulses it produces, then one idle cycle.
  task automatic tick_once();
    bus.tick = 1'b1;
    cyc();
    got_ack   = bus.drop_ack;
    got_nack  = bus.drop_nack;
    got_start = bus.explode_start;
    bus.tick  = 1'b0;
    cyc();
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) tick_once();
  endtask

  task automatic drop(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    bus.pos_x    = x;
    bus.pos_y    = y;
    bus.drop_btn = 1'b1;
    cyc();
    bus.drop_btn = 1'b0;
    cyc();
    tick_once();
  endtask

  function automatic logic [COORD_W-1:0] slot_x(input int s);
    return bus.bomb_x[s*COORD_W +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] slot_y(input int s);
    return bus.bomb_y[s*COORD_W +: COORD_W];
  endfunction

  initial begin
    bus.tick = 1'b0; bus.game_en = 1'b1; bus.drop_btn = 1'b0;
    bus.pos_x = '0; bus.pos_y = '0;
    repeat (3) cyc();
    check("rst_armed",  32'(bus.armed), 0);
    check("rst_active", 32'(bus.active_cnt), 0);
    check("rst_ack",    32'(bus.drop_ack), 0);
    check("rst_bx",     32'(bus.bomb_x), 0);
    reset_n = 1'b1;
    cyc();

    // Single bomb lifecycle with blink
    drop(10'd100, 10'd240);
    check("single_ack",   32'(got_ack), 1);
    check("single_nack",  32'(got_nack), 0);
    check("single_armed", 32'(bus.armed), 32'b01);
    check("single_x",     32'(slot_x(0)), 100);
    check("single_y",     32'(slot_y(0)), 240);
    check("vis_96",       32'(bus.visible), 32'b01);
    check("single_act",   32'(bus.active_cnt), 1);
    run_ticks(1);
    check("vis_95",       32'(bus.visible), 0);
    run_ticks(8);
    check("vis_87",       32'(bus.visible), 32'b01);
    run_ticks(86);
    check("armed_95",     32'(bus.armed), 32'b01);
    check("noexp_95",     32'(bus.exploding), 0);
    tick_once();
    check("exp_start",    32'(got_start), 32'b01);
    check("exp_96",       32'(bus.exploding), 32'b01);
    check("disarm_96",    32'(bus.armed), 0);
    check("start_pulse",  32'(bus.explode_start), 0);
    run_ticks(23);
    check("exp_23",       32'(bus.exploding), 32'b01);
    tick_once();
    check("exp_done",     32'(bus.exploding), 0);
    check("idle_act",     32'(bus.active_cnt), 0);
    check("hold_x",       32'(slot_x(0)), 100);

    // Full: third drop refused
    drop(10'd100, 10'd240);
    check("full_ack0", 32'(got_ack), 1);
    drop(10'd200, 10'd240);
    check("full_ack1", 32'(got_ack), 1);
    drop(10'd300, 10'd240);
    check("full_nack", 32'(got_nack), 1);
    check("full_noack", 32'(got_ack), 0);
    check("full_act",  32'(bus.active_cnt), 2);
    check("full_x1",   32'(slot_x(1)), 200);
    run_ticks(125);
    check("full_drain", 32'(bus.active_cnt), 0);

    // Duplicate, then slot-freeing race
    drop(10'd100, 10'd240);
    check("dup_ack",  32'(got_ack), 1);
    drop(10'd100, 10'd240);
    check("dup_nack", 32'(got_nack), 1);
    run_ticks(48);
    drop(10'd200, 10'd240);
    check("race_ack1",  32'(got_ack), 1);
    check("race_armed", 32'(bus.armed), 32'b11);
    run_ticks(69);
    check("race_exp0",  32'(bus.exploding), 32'b01);
    drop(10'd300, 10'd240);
    check("race_nack",  32'(got_nack), 1);
    check("race_free",  32'(bus.exploding), 0);
    check("race_arm1",  32'(bus.armed), 32'b10);
    drop(10'd300, 10'd240);
    check("race_ack0",  32'(got_ack), 1);
    check("race_arm2",  32'(bus.armed), 32'b11);
    check("race_x0",    32'(slot_x(0)), 300);
    check("race_x1",    32'(slot_x(1)), 200);

    // game_en clear
    bus.game_en = 1'b0;
    cyc();
    check("ge_armed", 32'(bus.armed), 0);
    check("ge_act1",  32'(bus.active_cnt), 2);
    cyc();
    check("ge_act2",  32'(bus.active_cnt), 0);
    drop(10'd400, 10'd240);
    check("ge_noack",  32'(got_ack), 0);
    check("ge_nonack", 32'(got_nack), 0);
    bus.game_en = 1'b1;
    cyc();
    drop(10'd100, 10'd240);
    check("ge_ack",   32'(got_ack), 1);
    check("ge_slot0", 32'(bus.armed), 32'b01);

    // Async reset mid-countdown
    run_ticks(10);
    reset_n = 1'b0;
    #1;
    check("arst_armed", 32'(bus.armed), 0);
    check("arst_bx",    32'(bus.bomb_x), 0);
    check("arst_vis",   32'(bus.visible), 0);
    check("arst_act",   32'(bus.active_cnt), 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    drop(10'd500, 10'd100);
    check("post_ack",   32'(got_ack), 1);
    check("post_armed", 32'(bus.armed), 32'b01);
    check("post_x",     32'(slot_x(0)), 500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
